buffered_uart_rx: RTL and testbench
===================================

// Module: buffered_uart_rx
// PURPOSE
//  UART receiver with an output FIFO, the receive counterpart of the buffered UART transmitter.
//  - Deserialises 8N1 frames from the serial line into bytes and buffers them.
//  - The host/USB side drains bytes at its own pace through a first-word-fall-through read port.
//  - Reports framing errors and FIFO overflow.
// PARAMETERS
//  CLKS_PER_BIT  217  clk cycles per serial bit (25 MHz / 115200); must be >= 4
//  DEPTH_LOG2    4    log2 of FIFO depth (default 16 entries)
// PORTS
//  clk        in   1             system clock; all logic on posedge
//  rst        in   1             synchronous reset, active-high
//  uart_rx    in   1             asynchronous serial input, idles high
//  rd_en      in   1             pop head byte; ignored while empty
//  rd_data    out  8             FIFO head byte; valid while empty=0
//  empty      out  1             FIFO holds no bytes
//  full       out  1             FIFO holds 2**DEPTH_LOG2 bytes
//  level      out  DEPTH_LOG2+1  current FIFO occupancy
//  frame_err  out  1             1-cycle pulse: stop bit sampled low
//  overflow   out  1             sticky: a byte was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - FSM enters IDLE; FIFO is flushed.
//  - Outputs: empty=1, full=0, level=0, frame_err=0, overflow=0, rd_data=8'h00.
//  - Synchroniser flops are set to 1.
//  - rst asserted mid-frame abandons the frame; the partial byte is never written.
//  Input synchroniser:
//  - uart_rx passes through 2 flops (rx_s) before use, adding 2 cycles of latency.
//  FSM: bit_cnt counts 0..CLKS_PER_BIT-1; idx counts 0..7.
//  - IDLE: on rx_s==0, go to START with bit_cnt cleared.
//  - START: at bit_cnt==CLKS_PER_BIT/2-1, sample rx_s.
//      - 0: go to DATA with bit_cnt cleared.
//      - 1: glitch; return to IDLE, nothing is reported.
//  - DATA: every CLKS_PER_BIT cycles, sample at mid-bit into sh[idx]. Data is LSB first.
//      After idx==7, go to PARITY (macro on) or STOP (macro off).
//  - PARITY: sample at mid-bit (see CONFIGURATION), then go to STOP.
//  - STOP: sample at mid-bit, then go to IDLE on the next cycle. Nothing waits for the end
//      of the stop bit, so back-to-back frames are accepted.
//      - rx_s==1: byte is pushed.
//      - rx_s==0: frame_err pulses for 1 cycle and the byte is discarded.
//  Latency:
//  - A pushed byte is visible one cycle after the stop-sample cycle: empty=0, rd_data valid,
//    level incremented.
//  FIFO (circular; pointers DEPTH_LOG2+1 bits, wrapping modulo 2**(DEPTH_LOG2+1)):
//  - rd_data always shows the head entry. A pop with rd_en=1 takes effect at the posedge;
//    the next entry appears in the following cycle.
//  - Push while full, without a pop in the same cycle: the byte is dropped and overflow is
//    set to 1. overflow stays 1 until rst.
//  - Push and pop in the same cycle: both happen and level is unchanged. This holds when
//    full; no overflow is flagged.
//  - Pop while empty: no effect; pointers are unchanged.
//  - full = (level == 2**DEPTH_LOG2); empty = (level == 0).
// CONFIGURATION
//  BUFFERED_UART_RX_PARITY_EN defined:
//  - Frame is 8E1. The PARITY state samples the bit after data bit 7.
//  - If XOR(data bits, parity bit) != 0, frame_err pulses and the byte is dropped.
//    This happens at the stop-sample cycle, even if the stop bit is valid.
//  BUFFERED_UART_RX_PARITY_EN undefined:
//  - Frame is 8N1. The PARITY state and its logic are absent.
// TESTING (CLKS_PER_BIT=8, DEPTH_LOG2=2)
//  1. Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> empty=0, rd_data=8'hA5, level=1;
//     pulse rd_en -> empty=1, level=0.
//  2. Low pulse on uart_rx of 2 cycles -> returns to IDLE; empty=1, frame_err=0.
//  3. Frame 0x3C with the stop bit driven 0 -> frame_err high exactly 1 cycle; empty stays 1.
//  4. 5 back-to-back frames 0x01..0x05, no reads -> full=1, level=4, overflow=1;
//     reads return 0x01..0x04; then empty=1 and overflow stays 1 until rst.
//  5. rst pulsed during data bit 4 of a 0xFF frame, then frame 0x5A -> only 0x5A is received.
//  6. Parity macro on: frame 0x07 with parity bit 1 -> accepted as 8'h07;
//     same frame with parity bit 0 -> frame_err pulse, empty=1.

Source files
------------

// File: rtl/buffered_uart_rx.sv
// UART receiver (8N1, or 8E1 with BUFFERED_UART_RX_PARITY_EN) feeding a first-word-fall-through FIFO.
// Reports framing/parity errors as a 1-cycle pulse and sticky FIFO overflow.
module buffered_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  frame_err,
    output logic                  overflow
);

    localparam int unsigned CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef BUFFERED_UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic          rx_meta, rx_s;
    state_t        state, state_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          push, ferr_n;
`ifdef BUFFERED_UART_RX_PARITY_EN
    logic          par, par_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            idx       <= '0;
            sh        <= '0;
            frame_err <= 1'b0;
`ifdef BUFFERED_UART_RX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            frame_err <= ferr_n;
`ifdef BUFFERED_UART_RX_PARITY_EN
            par       <= par_n;
`endif
        end
    end

    // Every sample point after START is one full bit period after the previous one,
    // so the START half-bit offset keeps all later samples at mid-bit.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt + 1'b1;
        idx_n     = idx;
        sh_n      = sh;
        push      = 1'b0;
        ferr_n    = 1'b0;
`ifdef BUFFERED_UART_RX_PARITY_EN
        par_n     = par;
`endif
        unique case (state)
            S_IDLE: begin
                bit_cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (bit_cnt == HALF_CNT) begin
                    bit_cnt_n = '0;
                    idx_n     = '0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_n = '0;
                    sh_n[idx] = rx_s;
                    idx_n     = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef BUFFERED_UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef BUFFERED_UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_n = '0;
                    par_n     = rx_s;
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_n = '0;
                    state_n   = S_IDLE;
`ifdef BUFFERED_UART_RX_PARITY_EN
                    if (rx_s && !(^{sh, par})) push = 1'b1;
`else
                    if (rx_s) push = 1'b1;
`endif
                    else ferr_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                pop, wr_ok;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign pop     = rd_en && !empty;
    // When full, a simultaneous pop frees the head slot, which is the slot being written.
    assign wr_ok   = push && (!full || pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && !wr_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_buffered_uart_rx.sv
// Self-checking bench for buffered_uart_rx (CLKS_PER_BIT=8, DEPTH_LOG2=2); honours BUFFERED_UART_RX_PARITY_EN.
module tb_buffered_uart_rx;

    localparam int CPB   = 8;
    localparam int DL    = 2;
    localparam int DEPTH = 4;
`ifdef BUFFERED_UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, uart_rx, rd_en;
    logic [7:0]    rd_data;
    logic          empty, full, frame_err, overflow;
    logic [DL:0]   level;

    buffered_uart_rx #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .level(level), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;

    always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

    // Reference model: byte queue plus sticky overflow flag.
    byte unsigned q[$];
    bit           m_ovf;

    typedef struct {
        byte unsigned data;
        bit           stop;
        bit           par_bad;
        int           n_reads;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        uart_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input byte unsigned d, input bit stop_v, input bit par_bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR) send_bit((^d) ^ par_bad);
        send_bit(stop_v);
        uart_rx = 1'b1;
    endtask

    function automatic bit model_rx(input byte unsigned d, input bit stop_v, input bit par_bad);
        bit ok = stop_v && !(PAR && par_bad);
        if (ok) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1'b1;
        end
        return !ok;
    endfunction

    task automatic check_state(input string nm);
        chk({nm, ".level"}, int'(level), q.size());
        chk({nm, ".empty"}, int'(empty), int'(q.size() == 0));
        chk({nm, ".full"}, int'(full), int'(q.size() == DEPTH));
        chk({nm, ".overflow"}, int'(overflow), int'(m_ovf));
        if (q.size() > 0) chk({nm, ".rd_data"}, int'(rd_data), int'(q[0]));
    endtask

    task automatic do_pop(input string nm);
        check_state(nm);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic run_frame(input string nm, input byte unsigned d, input bit stop_v,
                             input bit par_bad, input int n_reads);
        int fe0 = fe_cnt;
        bit exp_fe;
        send_frame(d, stop_v, par_bad);
        exp_fe = model_rx(d, stop_v, par_bad);
        idle(CPB);
        chk({nm, ".frame_err_pulses"}, fe_cnt - fe0, int'(exp_fe));
        check_state(nm);
        for (int r = 0; r < n_reads; r++) do_pop({nm, ".pop"});
        check_state({nm, ".after"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   fe0;
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 0};
        tbl[2] = '{8'h07, 1'b1, 1'b0, 0};
        tbl[3] = '{8'h07, 1'b1, 1'b1, 0};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 0};
        tbl[5] = '{8'h00, 1'b1, 1'b0, 3};
        tbl[6] = '{8'h80, 1'b0, 1'b0, 0};
        tbl[7] = '{8'h55, 1'b1, 1'b0, 2};

        uart_rx = 1'b1;
        rd_en   = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        do_reset();
        idle(2);
        chk("reset.empty", int'(empty), 1);
        chk("reset.full", int'(full), 0);
        chk("reset.level", int'(level), 0);
        chk("reset.frame_err", int'(frame_err), 0);
        chk("reset.overflow", int'(overflow), 0);
        chk("reset.rd_data", int'(rd_data), 0);

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("vec%0d", i), tbl[i].data, tbl[i].stop, tbl[i].par_bad, tbl[i].n_reads);

        // Short low glitch must not start a frame.
        fe0 = fe_cnt;
        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(3 * CPB);
        chk("glitch.frame_err_pulses", fe_cnt - fe0, 0);
        check_state("glitch");

        // Back-to-back frames overrun the 4-entry FIFO.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            send_frame(byte'(i), 1'b1, 1'b0);
            void'(model_rx(byte'(i), 1'b1, 1'b0));
        end
        idle(4);
        chk("b2b.full", int'(full), 1);
        chk("b2b.level", int'(level), 4);
        chk("b2b.overflow", int'(overflow), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("b2b.rd_data", int'(rd_data), i);
            do_pop("b2b.pop");
        end
        check_state("b2b.drained");
        chk("b2b.empty", int'(empty), 1);
        chk("b2b.overflow_sticky", int'(overflow), 1);
        do_reset();
        idle(1);
        chk("b2b.overflow_cleared", int'(overflow), 0);

        // Reset during data bit 4 of a 0xFF frame abandons it.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        uart_rx = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        idle(5 * CPB);
        check_state("midrst.idle");
        chk("midrst.empty", int'(empty), 1);
        run_frame("midrst.5A", 8'h5A, 1'b1, 1'b0, 0);
        chk("midrst.rd_data", int'(rd_data), 8'h5A);
        chk("midrst.level", int'(level), 1);

        // Randomised frames, errors and reads against the model.
        for (int n = 0; n < 40; n++) begin
            run_frame($sformatf("rnd%0d", n), byte'($urandom_range(0, 255)),
                      $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                      int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
